// File: rtl/snake_ctrl.sv
// snake_ctrl: game sequencer for the snake datapath. It synchronises and
// debounces the four direction buttons, keeps the pending direction, paces
// steps from frame_tick and hands each step to the datapath with a
// step_req/step_ack handshake.
//
// state | meaning
// IDLE  | no game running, waiting for any debounced press
// PLAY  | counting frame ticks toward the next step
// WAIT  | step_req raised, dir frozen, waiting for step_ack
// DEAD  | game over; needs a full release and then a fresh press
module snake_ctrl #(
    parameter int unsigned STEP_FRAMES = 8,
    parameter int unsigned DB_FRAMES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       step_ack,
    input  logic       collision,
    input  logic       grow,
    output logic       step_req,
    output logic       clear_req,
    output logic [1:0] dir,
    output logic [1:0] game_state,
    output logic [7:0] score
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WAIT = 2'b11,
        S_DEAD = 2'b10
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam logic [3:0] DB_MAX    = 4'(DB_FRAMES);
    localparam logic [7:0] STEP_MAX  = 8'(STEP_FRAMES);

    // button vectors are ordered {up, down, left, right}
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] db_cnt_q [4];
    logic [3:0] db_cnt_d [4];
    logic [3:0] pressed;
    logic       any_press;
    logic [1:0] cand;
    logic       cand_rev;

    state_t     state_q, state_d;
    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] score_q, score_d;
    logic [7:0] frame_q, frame_d;
    logic       clear_q, clear_d;
    logic       armed_q, armed_d;

    // two-flop synchroniser for the raw buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {up, down, left, right};
            sync2_q <= sync1_q;
        end
    end

    // debounce: count consecutive high samples on frame_tick, drop on a low one
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (frame_tick) begin
                if (!sync2_q[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] != DB_MAX) begin
                    db_cnt_d[i] = db_cnt_q[i] + 4'd1;
                end
            end
        end
    end

    // debounce counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // pressed flags and priority pick of the candidate direction
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pressed[i] = (db_cnt_q[i] == DB_MAX);
        end
        any_press = |pressed;
        cand      = DIR_RIGHT;
        if (pressed[3]) begin
            cand = DIR_UP;
        end else if (pressed[2]) begin
            cand = DIR_DOWN;
        end else if (pressed[1]) begin
            cand = DIR_LEFT;
        end
        // opposite directions share bit 1 and differ in bit 0
        cand_rev = (cand == {dir_q[1], ~dir_q[0]});
    end

    // next-state and datapath-register logic of the game FSM
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        score_d = score_q;
        frame_d = frame_q;
        clear_d = 1'b0;
        armed_d = armed_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_press) begin
                    state_d = S_PLAY;
                    clear_d = 1'b1;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                    score_d = '0;
                    frame_d = '0;
                end
            end
            S_PLAY: begin
                if (any_press && !cand_rev) begin
                    pend_d = cand;
                end
                if (frame_q == STEP_MAX) begin
                    dir_d   = pend_q;
                    frame_d = '0;
                    state_d = S_WAIT;
                end else if (frame_tick) begin
                    frame_d = frame_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (any_press && !cand_rev) begin
                    pend_d = cand;
                end
                if (step_ack) begin
                    if (collision) begin
                        state_d = S_DEAD;
                        armed_d = 1'b0;
                    end else begin
                        state_d = S_PLAY;
                        if (grow && score_q != 8'hFF) begin
                            score_d = score_q + 8'd1;
                        end
                    end
                end
            end
            S_DEAD: begin
                // a press held over from the fatal step must be released first
                if (!any_press) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // game FSM and its registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            score_q <= '0;
            frame_q <= '0;
            clear_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            score_q <= score_d;
            frame_q <= frame_d;
            clear_q <= clear_d;
            armed_q <= armed_d;
        end
    end

    // outputs decoded from registered state
    always_comb begin
        step_req   = (state_q == S_WAIT);
        clear_req  = clear_q;
        dir        = dir_q;
        score      = score_q;
        game_state = 2'b00;
        if (state_q == S_PLAY || state_q == S_WAIT) begin
            game_state = 2'b01;
        end else if (state_q == S_DEAD) begin
            game_state = 2'b10;
        end
    end

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_FRAMES, default 8: frame_tick pulses per snake step, legal range 1-255.
REQ-002 The block SHALL have parameter DB_FRAMES, default 2: consecutive frame samples a button must stay high to count as pressed, legal range 1-15.
REQ-003 Port clk  in  1: single system clock; all state on rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Port frame_tick  in  1: one-cycle pulse per video frame, from VGA timing.
REQ-006 Ports up, down, left, right  in  1 each: raw, asynchronous, active-high buttons.
REQ-007 Port step_ack  in  1: one-cycle pulse from the snake datapath when the requested step is complete.
REQ-008 Port collision  in  1: valid only while step_ack=1; the step hit wall or body.
REQ-009 Port grow  in  1: valid only while step_ack=1; the step ate food.
REQ-010 Port step_req  out  1: level request to the datapath to advance one cell in direction dir.
REQ-011 Port clear_req  out  1: one-cycle pulse telling the datapath to reinitialise the snake body and food.
REQ-012 Port dir  out  2: 00 up, 01 down, 10 left, 11 right; stable while step_req=1.
REQ-013 Port game_state  out  2: 00 IDLE, 01 PLAY, 10 DEAD; 11 SHALL never occur.
REQ-014 Port score  out  8: foods eaten this game, unsigned.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser before any other use.
REQ-016 Debounce SHALL sample the synchronised buttons only on frame_tick; a button is "pressed" after DB_FRAMES consecutive high samples and "released" on the first low sample.
REQ-017 If several buttons are pressed together, the candidate direction SHALL be chosen by priority up > down > left > right.
REQ-018 A candidate that is the exact reverse of the current dir SHALL be discarded, and the pending direction SHALL stay unchanged.
REQ-019 An accepted candidate SHALL overwrite the pending direction register; the last accepted candidate wins.
REQ-020 The internal FSM SHALL have states IDLE, PLAY, WAIT and DEAD; game_state SHALL show PLAY while in either PLAY or WAIT.
REQ-021 IDLE -> PLAY SHALL occur on the first cycle any debounced press is present; on that transition:
- clear_req pulses for exactly 1 cycle;
- score, dir and pending direction are set to 11 (right) where applicable, score to 0;
- the frame counter is set to 0.
REQ-022 In PLAY, every frame_tick SHALL increment the frame counter; when the counter reaches STEP_FRAMES, on the next edge the FSM SHALL:
- load dir from the pending direction;
- set step_req=1;
- zero the counter;
- enter WAIT.
REQ-023 In WAIT, step_req SHALL stay 1, dir SHALL stay frozen, and the frame counter SHALL not advance; debounce and pending-direction updates SHALL continue.
REQ-024 On step_ack in WAIT, step_req SHALL drop on the next edge, with outcome as follows:
- collision=1: the FSM enters DEAD and score is unchanged;
- otherwise: the FSM returns to PLAY, and score increments when grow=1, saturating at 255.
REQ-025 collision SHALL take precedence over grow when both are 1.
REQ-026 step_ack, collision and grow SHALL be ignored outside WAIT.
REQ-027 If step_ack and frame_tick coincide, the ack SHALL be processed and the tick SHALL not be counted.
REQ-028 DEAD SHALL hold score and dir; it SHALL go to IDLE only after all buttons are released and a new debounced press follows.
REQ-029 Total latency from a debounced press in IDLE to clear_req SHALL be 1 cycle.

Reset
REQ-030 While reset=1, outputs SHALL take these values immediately, independent of clk: step_req=0, clear_req=0, dir=11, game_state=00, score=0.
REQ-031 While reset=1, internal state SHALL be: FSM in IDLE, frame counter 0, debounce counters 0, synchronisers 0.
REQ-032 Reset asserted in WAIT SHALL drop step_req at once, and any later step_ack SHALL be ignored.
REQ-033 After reset deasserts, the first press SHALL need the full synchroniser + DB_FRAMES delay.

Verification
REQ-034 Start-up with STEP_FRAMES=4, DB_FRAMES=2: hold up for 2 frame_ticks -> clear_req pulses 1 cycle, game_state=01, dir=11; after 4 further ticks -> step_req=1 with dir=00.
REQ-035 Reversal check, dir=11: press left -> pending direction unchanged, next step dir=11; press left+up together -> next step dir=00.
REQ-036 Handshake: hold step_ack=0 for 10 frame_ticks -> step_req stays 1 and no second step is issued; then step_ack=1 with grow=1 -> score 0->1 and step_req=0 next cycle.
REQ-037 Saturation and death: reach score 255, then ack with grow=1 -> score stays 255; then ack with collision=1 and grow=1 -> game_state=10, score=255.
REQ-038 DEAD exit: keep a button held from DEAD entry -> FSM stays DEAD; release, then press for 2 ticks -> game_state=00, then 01 with a clear_req pulse.
REQ-039 Reset mid-WAIT: assert reset asynchronously between clock edges -> step_req=0 and score=0 before the next edge; a step_ack after release -> no change.
